multicycle_control_fsm: RTL and testbench
=========================================

# multicycle_control_fsm

Control sequencer for the multicycle RV32I core: walks each instruction through fetch, decode, execute, memory and writeback states and drives the shared ALU, register file, immediate extender and unified instruction/data memory port. It replaces the single-cycle main decoder in the multicycle build and sits between the instruction register opcode field and the datapath mux and enable controls. It waits on the memory port through a request/ready handshake, so memory latency is variable.

## Interface
- Parameters: none.
- clk  in  1  core clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- op  in  7  opcode from the instruction register (IR[6:0]).
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory access request.
- mem_write  out  1  request is a store.
- adr_src  out  1  memory address select: 0 = PC, 1 = Result.
- ir_write  out  1  load IR and OldPC.
- pc_write  out  1  PC enable; equals pc_update OR (branch AND zero).
- reg_write  out  1  register file write enable.
- alu_src_a  out  2  00 = PC, 01 = OldPC, 10 = RD1.
- alu_src_b  out  2  00 = RD2, 01 = ImmExt, 10 = constant 4.
- alu_op  out  2  00 = add, 01 = subtract (branch), 10 = funct-decoded.
- result_src  out  2  00 = ALUOut, 01 = read data, 10 = ALUResult.
- imm_src  out  2  00 = S, 01 = B, 10 = I, 11 = J; decoded from op in every state.
- instr_done  out  1  one-cycle pulse on the final cycle of each instruction.
- illegal  out  1  sticky flag set on an unsupported opcode.

## Operation
- Moore FSM with a 4-bit state register. Outputs are combinational from the state, except the pc_write term on zero and the ready-gated ir_write and pc_update. Any output not listed for a state is 0.
- FETCH: mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10.
  - ir_write and pc_update equal mem_ready.
  - Stays in FETCH until mem_ready is high, then moves to DECODE.
- DECODE: alu_src_a=01, alu_src_b=01, alu_op=00, which precomputes the branch target into ALUOut. Next state by op:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BEQ
  - 1101111 → JAL (only when the JAL feature is compiled in)
  - any other opcode → TRAP
- MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00. Goes to MEMREAD if op=0000011, otherwise to MEMWRITE.
- MEMREAD: mem_req=1, adr_src=1, result_src=00. Waits for mem_ready, then goes to MEMWB.
- MEMWB: result_src=01, reg_write=1, instr_done=1. Goes to FETCH.
- MEMWRITE: mem_req=1, mem_write=1, adr_src=1, result_src=00. Waits for mem_ready; on that cycle instr_done=1 and the next state is FETCH.
- EXECR: alu_src_a=10, alu_src_b=00, alu_op=10. Goes to ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01, alu_op=10. Goes to ALUWB.
- ALUWB: result_src=00, reg_write=1, instr_done=1. Goes to FETCH.
- BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, branch=1, instr_done=1. Goes to FETCH.
- JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_update=1. Goes to ALUWB.
- TRAP: illegal=1 and all other outputs 0. Stays in TRAP until rst.
- mem_ready is ignored in any state that does not assert mem_req.

## Timing
- While rst is high, the state is FETCH and every output is forced to 0, including mem_req.
- The first request is issued in the first cycle after rst deasserts.
- mem_ready may rise in the same cycle mem_req rises (zero-wait memory). With zero-wait memory, cycles per instruction are:
  - lw 5
  - sw 4
  - R-type 4
  - I-type ALU 4
  - jal 4
  - beq 3
- Each wait cycle on mem_ready adds exactly one cycle and holds all outputs stable.
- rst asserted mid-instruction, including mid-wait, aborts immediately. There is no partial writeback after reset.
- op must stay stable from DECODE to instruction end. The FSM does not latch op.

## Configuration
- JAL_EN defined: opcode 1101111 is supported through the DECODE → JAL → ALUWB path. rd receives PC+4 via ALUOut, and the PC is loaded with the target.
- JAL_EN undefined: the JAL state is not built, and opcode 1101111 goes to TRAP.

## Test plan
- Reset, then lw with zero-wait memory → mem_req falls during rst; states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; reg_write=1 on cycle 5 only; instr_done pulses once.
- sw with mem_ready delayed 3 cycles in MEMWRITE → mem_write=1 held for 4 cycles, outputs stable, then FETCH; reg_write never asserts.
- beq with zero=1, then with zero=0 → pc_write=1 in BEQ only when zero=1; 3 cycles each.
- add (0110011) then addi (0010011) → alu_op=10 in the execute state; alu_src_b is 00 for add and 01 for addi; imm_src=10 for addi.
- Opcode 1101111 → with JAL_EN: pc_write=1 in JAL, reg_write=1 in ALUWB. Without JAL_EN: TRAP, illegal=1 and sticky, mem_req stays 0 until rst.
- rst asserted during MEMREAD wait → all outputs 0 immediately; FETCH request in the first cycle after release.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I control sequencer: fetch/decode/execute/memory/writeback walk
// with a ready-handshaked memory port. Define JAL_EN to build the jal path.
module multicycle_control_fsm (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] result_src,
    output logic [1:0] imm_src,
    output logic       instr_done,
    output logic       illegal
);
    localparam logic [6:0] opLoad  = 7'b0000011;
    localparam logic [6:0] opStore = 7'b0100011;
    localparam logic [6:0] opRType = 7'b0110011;
    localparam logic [6:0] opIType = 7'b0010011;
    localparam logic [6:0] opBeq   = 7'b1100011;
    localparam logic [6:0] opJal   = 7'b1101111;

    typedef enum logic [3:0] {
        sFetch    = 4'd0,
        sDecode   = 4'd1,
        sMemAdr   = 4'd2,
        sMemRead  = 4'd3,
        sMemWb    = 4'd4,
        sMemWrite = 4'd5,
        sExecR    = 4'd6,
        sExecI    = 4'd7,
        sAluWb    = 4'd8,
        sBeq      = 4'd9,
        sTrap     = 4'd11
`ifdef JAL_EN
        , sJal    = 4'd10
`endif
    } state_t;

    typedef struct packed {
        logic       memReq;
        logic       memWrite;
        logic       adrSrc;
        logic       irWrite;
        logic       pcUpdate;
        logic       branch;
        logic       regWrite;
        logic [1:0] aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] aluOp;
        logic [1:0] resultSrc;
        logic [1:0] immSrc;
        logic       instrDone;
        logic       illegal;
    } ctrl_t;

    state_t state, nextState;
    ctrl_t  ctrl, ctrlOut;
    logic [1:0] immDec;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= sFetch;
        else     state <= nextState;
    end

    always_comb begin
        immDec = 2'b00;
        case (op)
            opStore:         immDec = 2'b00;
            opBeq:           immDec = 2'b01;
            opLoad, opIType: immDec = 2'b10;
            opJal:           immDec = 2'b11;
            default:         immDec = 2'b00;
        endcase
    end

    always_comb begin
        nextState   = state;
        ctrl        = '0;
        ctrl.immSrc = immDec;
        case (state)
            sFetch: begin
                ctrl.memReq    = 1'b1;
                ctrl.aluSrcB   = 2'b10;
                ctrl.resultSrc = 2'b10;
                ctrl.irWrite   = mem_ready;
                ctrl.pcUpdate  = mem_ready;
                if (mem_ready) nextState = sDecode;
            end
            sDecode: begin
                // Branch target lands in ALUOut here so BEQ can commit it directly.
                ctrl.aluSrcA = 2'b01;
                ctrl.aluSrcB = 2'b01;
                case (op)
                    opLoad, opStore: nextState = sMemAdr;
                    opRType:         nextState = sExecR;
                    opIType:         nextState = sExecI;
                    opBeq:           nextState = sBeq;
`ifdef JAL_EN
                    opJal:           nextState = sJal;
`endif
                    default:         nextState = sTrap;
                endcase
            end
            sMemAdr: begin
                ctrl.aluSrcA = 2'b10;
                ctrl.aluSrcB = 2'b01;
                nextState    = (op == opLoad) ? sMemRead : sMemWrite;
            end
            sMemRead: begin
                ctrl.memReq = 1'b1;
                ctrl.adrSrc = 1'b1;
                if (mem_ready) nextState = sMemWb;
            end
            sMemWb: begin
                ctrl.resultSrc = 2'b01;
                ctrl.regWrite  = 1'b1;
                ctrl.instrDone = 1'b1;
                nextState      = sFetch;
            end
            sMemWrite: begin
                ctrl.memReq    = 1'b1;
                ctrl.memWrite  = 1'b1;
                ctrl.adrSrc    = 1'b1;
                ctrl.instrDone = mem_ready;
                if (mem_ready) nextState = sFetch;
            end
            sExecR: begin
                ctrl.aluSrcA = 2'b10;
                ctrl.aluOp   = 2'b10;
                nextState    = sAluWb;
            end
            sExecI: begin
                ctrl.aluSrcA = 2'b10;
                ctrl.aluSrcB = 2'b01;
                ctrl.aluOp   = 2'b10;
                nextState    = sAluWb;
            end
            sAluWb: begin
                ctrl.regWrite  = 1'b1;
                ctrl.instrDone = 1'b1;
                nextState      = sFetch;
            end
            sBeq: begin
                ctrl.aluSrcA   = 2'b10;
                ctrl.aluOp     = 2'b01;
                ctrl.branch    = 1'b1;
                ctrl.instrDone = 1'b1;
                nextState      = sFetch;
            end
`ifdef JAL_EN
            sJal: begin
                // ALUOut gets PC+4 for rd while the PC takes the target computed in DECODE.
                ctrl.aluSrcA  = 2'b01;
                ctrl.aluSrcB  = 2'b10;
                ctrl.pcUpdate = 1'b1;
                nextState     = sAluWb;
            end
`endif
            sTrap: begin
                ctrl         = '0;
                ctrl.illegal = 1'b1;
            end
            default: begin
                ctrl      = '0;
                nextState = sFetch;
            end
        endcase
    end

    // Reset masks every output, including the FETCH request the reset state would raise.
    assign ctrlOut    = rst ? '0 : ctrl;
    assign mem_req    = ctrlOut.memReq;
    assign mem_write  = ctrlOut.memWrite;
    assign adr_src    = ctrlOut.adrSrc;
    assign ir_write   = ctrlOut.irWrite;
    assign pc_write   = ctrlOut.pcUpdate | (ctrlOut.branch & zero);
    assign reg_write  = ctrlOut.regWrite;
    assign alu_src_a  = ctrlOut.aluSrcA;
    assign alu_src_b  = ctrlOut.aluSrcB;
    assign alu_op     = ctrlOut.aluOp;
    assign result_src = ctrlOut.resultSrc;
    assign imm_src    = ctrlOut.immSrc;
    assign instr_done = ctrlOut.instrDone;
    assign illegal    = ctrlOut.illegal;
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: per-cycle expected control words
// queued at drive time and checked mid-cycle.
module tb_multicycle_control_fsm;
    localparam logic [6:0] LW   = 7'b0000011;
    localparam logic [6:0] SW   = 7'b0100011;
    localparam logic [6:0] RT   = 7'b0110011;
    localparam logic [6:0] IT   = 7'b0010011;
    localparam logic [6:0] BEQ  = 7'b1100011;
    localparam logic [6:0] JAL  = 7'b1101111;

    logic clk = 1'b0;
    logic rst, zero, mem_ready;
    logic [6:0] op;
    logic mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, instr_done, illegal;
    logic [1:0] alu_src_a, alu_src_b, alu_op, result_src, imm_src;

    multicycle_control_fsm dut (
        .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src),
        .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .result_src(result_src), .imm_src(imm_src), .instr_done(instr_done),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef enum {tRst, tFetch, tDecode, tMemAdr, tMemRead, tMemWb, tMemWrite,
                  tExecR, tExecI, tAluWb, tBeq, tJal, tTrap} st_e;

    logic [19:0] expQ[$];
    int checks = 0;
    int errors = 0;

    // Word: memReq memWrite adrSrc irWrite pcWrite regWrite srcA srcB aluOp resSrc immSrc done illegal
    function automatic logic [19:0] expv(st_e s, logic [6:0] o, logic rdy, logic z);
        logic mr = 0, mw = 0, as = 0, irw = 0, pcw = 0, rw = 0, dn = 0, il = 0;
        logic [1:0] sa = 0, sb = 0, ao = 0, rs = 0, is = 0;
        case (o)
            SW:      is = 2'b00;
            BEQ:     is = 2'b01;
            LW, IT:  is = 2'b10;
            JAL:     is = 2'b11;
            default: is = 2'b00;
        endcase
        case (s)
            tFetch:    begin mr = 1; sb = 2'b10; rs = 2'b10; irw = rdy; pcw = rdy; end
            tDecode:   begin sa = 2'b01; sb = 2'b01; end
            tMemAdr:   begin sa = 2'b10; sb = 2'b01; end
            tMemRead:  begin mr = 1; as = 1; end
            tMemWb:    begin rs = 2'b01; rw = 1; dn = 1; end
            tMemWrite: begin mr = 1; mw = 1; as = 1; dn = rdy; end
            tExecR:    begin sa = 2'b10; ao = 2'b10; end
            tExecI:    begin sa = 2'b10; sb = 2'b01; ao = 2'b10; end
            tAluWb:    begin rw = 1; dn = 1; end
            tBeq:      begin sa = 2'b10; ao = 2'b01; pcw = z; dn = 1; end
            tJal:      begin sa = 2'b01; sb = 2'b10; pcw = 1; end
            tTrap:     begin is = 2'b00; il = 1; end
            default:   is = 2'b00;
        endcase
        return {mr, mw, as, irw, pcw, rw, sa, sb, ao, rs, is, dn, il};
    endfunction

    task automatic cyc(input st_e s, input logic r, input logic [6:0] o,
                       input logic rdy, input logic z);
        logic [19:0] e, got;
        rst = r; op = o; mem_ready = rdy; zero = z;
        expQ.push_back(expv(s, o, rdy, z));
        @(negedge clk);
        got = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
               alu_src_a, alu_src_b, alu_op, result_src, imm_src, instr_done, illegal};
        e = expQ.pop_front();
        checks++;
        assert (got === e) else begin
            errors++;
            $error("FAIL %s op=%b rdy=%b zero=%b: observed %h expected %h",
                   s.name(), o, rdy, z, got, e);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        // Reset with ready high: request must stay low.
        cyc(tRst, 1, LW, 1, 0);
        cyc(tRst, 1, LW, 1, 0);
        // lw, zero-wait; ready high in non-request states must be ignored
        cyc(tFetch,   0, LW, 1, 0);
        cyc(tDecode,  0, LW, 1, 0);
        cyc(tMemAdr,  0, LW, 0, 0);
        cyc(tMemRead, 0, LW, 1, 0);
        cyc(tMemWb,   0, LW, 1, 0);
        // sw with three wait cycles
        cyc(tFetch,    0, SW, 1, 0);
        cyc(tDecode,   0, SW, 0, 0);
        cyc(tMemAdr,   0, SW, 1, 0);
        for (int i = 0; i < 3; i++) cyc(tMemWrite, 0, SW, 0, 0);
        cyc(tMemWrite, 0, SW, 1, 0);
        // beq taken, with one fetch wait; zero high outside BEQ is harmless
        cyc(tFetch,  0, BEQ, 0, 1);
        cyc(tFetch,  0, BEQ, 1, 1);
        cyc(tDecode, 0, BEQ, 0, 1);
        cyc(tBeq,    0, BEQ, 0, 1);
        // beq not taken
        cyc(tFetch,  0, BEQ, 1, 0);
        cyc(tDecode, 0, BEQ, 0, 0);
        cyc(tBeq,    0, BEQ, 0, 0);
        // add then addi
        cyc(tFetch,  0, RT, 1, 0);
        cyc(tDecode, 0, RT, 0, 0);
        cyc(tExecR,  0, RT, 0, 0);
        cyc(tAluWb,  0, RT, 0, 0);
        cyc(tFetch,  0, IT, 1, 0);
        cyc(tDecode, 0, IT, 0, 0);
        cyc(tExecI,  0, IT, 0, 0);
        cyc(tAluWb,  0, IT, 0, 0);
        // reset during MEMREAD wait, then a clean restart
        cyc(tFetch,   0, LW, 1, 0);
        cyc(tDecode,  0, LW, 0, 0);
        cyc(tMemAdr,  0, LW, 0, 0);
        cyc(tMemRead, 0, LW, 0, 0);
        cyc(tMemRead, 0, LW, 0, 0);
        cyc(tRst,     1, LW, 1, 0);
        cyc(tFetch,   0, LW, 0, 0);
        cyc(tFetch,   0, LW, 1, 0);
        cyc(tDecode,  0, LW, 0, 0);
        cyc(tMemAdr,  0, LW, 0, 0);
        cyc(tMemRead, 0, LW, 1, 0);
        cyc(tMemWb,   0, LW, 0, 0);
        // jal opcode
        cyc(tFetch,  0, JAL, 1, 0);
        cyc(tDecode, 0, JAL, 0, 0);
`ifdef JAL_EN
        cyc(tJal,    0, JAL, 0, 0);
        cyc(tAluWb,  0, JAL, 0, 0);
        cyc(tFetch,  0, LW, 0, 0);
`else
        cyc(tTrap,   0, JAL, 1, 1);
        cyc(tTrap,   0, LW, 1, 0);
        cyc(tTrap,   0, RT, 0, 0);
        cyc(tRst,    1, LW, 1, 0);
        cyc(tFetch,  0, LW, 1, 0);
        cyc(tDecode, 0, LW, 0, 0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
